// File: rtl/program_loader_if.sv
// Byte stream from the host plus the instruction-memory preload port.
// master = host side (byte source and preload sink), slave = the loader.
interface program_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        pre_ld;
  logic [31:0] pre_A;
  logic [31:0] pre_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, pre_ld, pre_A, pre_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, pre_ld, pre_A, pre_data
  );
endinterface

// File: rtl/program_loader.sv
// Serial boot loader: takes a little-endian word count followed by
// little-endian data words and writes them into instruction memory through
// its preload port, holding the CPU in reset while loading.
module program_loader #(
  parameter int unsigned N         = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  program_loader_if.slave    bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  localparam logic [31:0] MAX_W = 32'((N - BASE_ADDR) / 4);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_DATA, ST_SETUP, ST_STROBE, ST_DONE, ST_ERR
  } state_t;

  state_t      state, state_next;
  logic [1:0]  bc;         // byte lane within the current 32-bit word
  logic [31:0] wi;         // index of the word being loaded
  logic [31:0] w_len;      // word count from the header
  logic [31:0] asm_word;   // data word under assembly
  logic [31:0] pre_a_q;
  logic [31:0] pre_data_q;
  logic        done_q;

  logic        idle_like;
  logic        start_accept;
  logic        fire;
  logic        last_byte;
  logic [31:0] len_word;

  assign idle_like    = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign start_accept = idle_like && start;
  assign fire         = bus.in_valid && bus.in_ready;
  assign last_byte    = fire && (bc == 2'd3);
  // Header value including the byte arriving on this edge.
  assign len_word     = {bus.in_data, w_len[23:0]};

  // Outputs decoded from state only, so in_valid never reaches an output.
  assign bus.in_ready = (state == ST_LEN) || (state == ST_DATA);
  assign bus.pre_ld   = (state == ST_STROBE);
  assign bus.pre_A    = pre_a_q;
  assign bus.pre_data = pre_data_q;
  assign cpu_hold     = (state == ST_LEN) || (state == ST_DATA) ||
                        (state == ST_SETUP) || (state == ST_STROBE);
  assign err          = (state == ST_ERR);
  assign done         = done_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state selection.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned, which would infer a latch.
    state_next = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_next = ST_LEN;
      ST_LEN: begin
        if (last_byte) begin
          if (len_word == 32'd0)       state_next = ST_DONE;
          else if (len_word > MAX_W)   state_next = ST_ERR;
          else                         state_next = ST_DATA;
        end
      end
      ST_DATA:   if (last_byte) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_STROBE;
      ST_STROBE: state_next = (wi + 32'd1 == w_len) ? ST_DONE : ST_DATA;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Byte assembly, word index and preload address/data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc         <= 2'd0;
      wi         <= 32'd0;
      w_len      <= 32'd0;
      asm_word   <= 32'd0;
      pre_a_q    <= 32'd0;
      pre_data_q <= 32'd0;
    end else begin
      if (start_accept) begin
        bc <= 2'd0;
        wi <= 32'd0;
      end
      if (fire) begin
        bc <= bc + 2'd1;
        if (state == ST_LEN) w_len[{bc, 3'b000} +: 8]    <= bus.in_data;
        else                 asm_word[{bc, 3'b000} +: 8] <= bus.in_data;
      end
      // Address and data move only when entering SETUP, so they are stable
      // for a full cycle before the level-sensitive strobe.
      if ((state == ST_DATA) && last_byte) begin
        pre_data_q <= {bus.in_data, asm_word[23:0]};
        pre_a_q    <= 32'(BASE_ADDR) + {wi[29:0], 2'b00};
      end
      if (state == ST_STROBE) wi <= wi + 32'd1;
    end
  end

  // One-cycle done pulse on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= (state_next == ST_DONE) && (state != ST_DONE);
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random streams compared against a
// word-level model of the stream format and load timing.
module tb_program_loader;
  localparam int unsigned N     = 256;
  localparam int unsigned BASE  = 0;
  localparam int unsigned MAX_W = (N - BASE) / 4;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic cpu_hold, done, err;

  program_loader_if bus ();

  program_loader #(.N(N), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] got_a[$], got_d[$];
  logic [31:0] exp_a[$], exp_d[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: records every write and checks width, setup and spacing.
  logic [31:0] prev_a = '0, prev_d = '0;
  logic        prev_ld = 1'b0;
  int          last_strobe = -100;
  always @(negedge clk) begin
    if (bus.pre_ld === 1'b1) begin
      got_a.push_back(bus.pre_A);
      got_d.push_back(bus.pre_data);
      total++;
      if (bus.pre_A !== prev_a || bus.pre_data !== prev_d || prev_ld !== 1'b0) begin
        bad++;
        $display("FAIL strobe_setup: addr %h/%h data %h/%h prev_ld %b (strobe/setup cycle)",
                 bus.pre_A, prev_a, bus.pre_data, prev_d, prev_ld);
      end
      total++;
      if (cyc - last_strobe < 5) begin
        bad++;
        $display("FAIL strobe_gap: got %0d cycles apart, want >= 5", cyc - last_strobe);
      end
      last_strobe = cyc;
    end
    prev_a  = bus.pre_A;
    prev_d  = bus.pre_data;
    prev_ld = bus.pre_ld;
  end

  // Stream generator: header for w words followed by data_words random words.
  function automatic byte_q_t make_stream(input int unsigned w, input int data_words);
    byte_q_t b;
    for (int k = 0; k < 4; k++) b.push_back(8'(w >> (8 * k)));
    for (int i = 0; i < 4 * data_words; i++) b.push_back(8'($urandom_range(255)));
    return b;
  endfunction

  // Reference model: expected writes derived from the stream format.
  function automatic void model(input byte_q_t b, output int unsigned w, output bit is_err);
    w = {b[3], b[2], b[1], b[0]};
    is_err = (w > MAX_W);
    exp_a.delete();
    exp_d.delete();
    if (!is_err) begin
      for (int i = 0; i < int'(w); i++) begin
        exp_a.push_back(BASE + 4 * i);
        exp_d.push_back({b[4 + 4*i + 3], b[4 + 4*i + 2], b[4 + 4*i + 1], b[4 + 4*i]});
      end
    end
  endfunction

  function automatic int strobe_diff();
    int d = 0;
    if (got_a.size() != exp_a.size()) d++;
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) d++;
    return d;
  endfunction

  // Drives start then the byte stream. mode 0: in_valid held, 1: every other
  // cycle, 2: random. Stops on done, err, abort_at or the cycle limit.
  task automatic run_load(input byte_q_t b, input int mode, input int pulse_at,
                          input int abort_at, input int limit,
                          output int done_at, output int err_at,
                          output int consumed, output int hold_bad);
    int idx = 0;
    bit fire;
    done_at = -1; err_at = -1; hold_bad = 0;
    got_a.delete(); got_d.delete();
    @(posedge clk); #1;
    start = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (done === 1'b1) begin done_at = c; break; end
      if (err === 1'b1)  begin err_at = c;  break; end
      if (c == abort_at) break;
      if (cpu_hold !== 1'b1) hold_bad++;
      start = (c == pulse_at);
      bus.in_valid = (idx < b.size()) &&
                     (mode == 0 || (mode == 1 && c % 2 == 0) ||
                      (mode == 2 && $urandom_range(1) == 1));
      bus.in_data  = (idx < b.size()) ? b[idx] : 8'h00;
      fire = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (fire) idx++;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    consumed = idx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({bus.in_ready, bus.pre_ld, cpu_hold, done, err} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000",
                      {bus.in_ready, bus.pre_ld, cpu_hold, done, err});
    end
    total++;
    if (bus.pre_A !== 32'h0) begin bad++; $display("FAIL reset_pre_A: got %h want 0", bus.pre_A); end
    total++;
    if (bus.pre_data !== 32'h0) begin bad++; $display("FAIL reset_pre_data: got %h want 0", bus.pre_data); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.in_ready, bus.pre_ld, cpu_hold, done, err} !== 5'b0) begin
      bad++; $display("FAIL idle_ctrl: got %b want 00000",
                      {bus.in_ready, bus.pre_ld, cpu_hold, done, err});
    end
  endtask

  task automatic test_single_word();
    byte_q_t b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    int unsigned w; bit e; int d_at, e_at, cons, hb;
    model(b, w, e);
    run_load(b, 0, -1, -1, 40, d_at, e_at, cons, hb);
    total++;
    if (d_at !== 11) begin bad++; $display("FAIL single_done_cycle: got %0d want 11", d_at); end
    total++;
    if (hb !== 0) begin bad++; $display("FAIL single_hold: %0d low cycles before done, want 0", hb); end
    total++;
    if (cpu_hold !== 1'b0) begin bad++; $display("FAIL single_hold_done: got %b want 0", cpu_hold); end
    total++;
    if (got_a.size() !== 1 || strobe_diff() !== 0 || exp_d[0] !== 32'h00A00513) begin
      bad++; $display("FAIL single_strobe: got %0d strobes, %0d differ from model", got_a.size(), strobe_diff());
    end
    total++;
    if (cons !== 8) begin bad++; $display("FAIL single_consumed: got %0d want 8", cons); end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL single_done_width: got %b want 0", done); end
  endtask

  task automatic test_toggle();
    byte_q_t b = make_stream(3, 3);
    int unsigned w; bit e; int d_at, e_at, cons, hb;
    model(b, w, e);
    run_load(b, 1, -1, -1, 200, d_at, e_at, cons, hb);
    total++;
    if (d_at <= 0) begin bad++; $display("FAIL toggle_done: got cycle %0d want done", d_at); end
    total++;
    if (strobe_diff() !== 0) begin
      bad++; $display("FAIL toggle_strobes: got %0d strobes want %0d, %0d differ",
                      got_a.size(), exp_a.size(), strobe_diff());
    end
    total++;
    if (cons !== 16) begin bad++; $display("FAIL toggle_consumed: got %0d want 16", cons); end
  endtask

  task automatic test_zero();
    byte_q_t b = make_stream(0, 1);
    int d_at, e_at, cons, hb;
    run_load(b, 0, -1, -1, 30, d_at, e_at, cons, hb);
    total++;
    if (d_at !== 5) begin bad++; $display("FAIL zero_done_cycle: got %0d want 5", d_at); end
    total++;
    if (got_a.size() !== 0 || cons !== 4 || cpu_hold !== 1'b0) begin
      bad++; $display("FAIL zero_load: strobes %0d consumed %0d hold %b, want 0 4 0",
                      got_a.size(), cons, cpu_hold);
    end
  endtask

  task automatic test_max();
    byte_q_t b = make_stream(MAX_W, MAX_W);
    int unsigned w; bit e; int d_at, e_at, cons, hb;
    model(b, w, e);
    run_load(b, 0, -1, -1, 500, d_at, e_at, cons, hb);
    total++;
    if (d_at !== 5 + 6 * int'(MAX_W)) begin
      bad++; $display("FAIL max_done_cycle: got %0d want %0d", d_at, 5 + 6 * int'(MAX_W));
    end
    total++;
    if (strobe_diff() !== 0 || got_a.size() == 0 || got_a[got_a.size() - 1] !== 32'hFC) begin
      bad++; $display("FAIL max_strobes: got %0d strobes want %0d, %0d differ",
                      got_a.size(), exp_a.size(), strobe_diff());
    end
  endtask

  task automatic test_overflow();
    byte_q_t b = make_stream(MAX_W + 1, 2);
    byte_q_t z = make_stream(0, 0);
    int d_at, e_at, cons, hb;
    run_load(b, 0, -1, -1, 30, d_at, e_at, cons, hb);
    total++;
    if (e_at !== 5 || cons !== 4) begin
      bad++; $display("FAIL ovf_err: err at %0d consumed %0d, want 5 and 4", e_at, cons);
    end
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({err, bus.in_ready, cpu_hold} !== 3'b100 || got_a.size() !== 0) begin
      bad++; $display("FAIL ovf_hold: err/ready/hold %b strobes %0d, want 100 and 0",
                      {err, bus.in_ready, cpu_hold}, got_a.size());
    end
    bus.in_valid = 1'b0;
    run_load(z, 0, -1, -1, 30, d_at, e_at, cons, hb);
    total++;
    if (e_at !== -1 || d_at !== 5 || hb !== 0) begin
      bad++; $display("FAIL ovf_restart: err at %0d done at %0d hold gaps %0d, want -1 5 0",
                      e_at, d_at, hb);
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t b = make_stream(2, 2);
    int unsigned w; bit e; int d_at, e_at, cons, hb;
    run_load(b, 0, -1, 12, 40, d_at, e_at, cons, hb);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.pre_ld, cpu_hold, done, err, bus.pre_A, bus.pre_data} !== 69'b0) begin
      bad++; $display("FAIL midrst_outputs: ctrl %b pre_A %h pre_data %h, want all 0",
                      {bus.in_ready, bus.pre_ld, cpu_hold, done, err}, bus.pre_A, bus.pre_data);
    end
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (got_a.size() !== 1) begin bad++; $display("FAIL midrst_strobes: got %0d want 1", got_a.size()); end
    b = make_stream(2, 2);
    model(b, w, e);
    run_load(b, 0, -1, -1, 40, d_at, e_at, cons, hb);
    total++;
    if (d_at !== 17 || strobe_diff() !== 0) begin
      bad++; $display("FAIL midrst_reload: done at %0d want 17, %0d strobes differ", d_at, strobe_diff());
    end
  endtask

  task automatic test_start_in_data();
    byte_q_t b = make_stream(2, 2);
    int unsigned w; bit e; int d_at, e_at, cons, hb;
    model(b, w, e);
    run_load(b, 0, 6, -1, 40, d_at, e_at, cons, hb);
    total++;
    if (d_at !== 17 || e_at !== -1 || cons !== 12 || strobe_diff() !== 0) begin
      bad++; $display("FAIL start_ignored: done %0d err %0d consumed %0d diff %0d, want 17 -1 12 0",
                      d_at, e_at, cons, strobe_diff());
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      int unsigned wr = $urandom_range(8, 1);
      byte_q_t b = make_stream(wr, int'(wr));
      int unsigned w; bit e; int d_at, e_at, cons, hb;
      model(b, w, e);
      run_load(b, 2, -1, -1, 600, d_at, e_at, cons, hb);
      total++;
      if (d_at <= 0 || hb !== 0 || cons !== 4 + 4 * int'(wr) || strobe_diff() !== 0) begin
        bad++; $display("FAIL b2b_load%0d: done %0d hold gaps %0d consumed %0d diff %0d, want >0 0 %0d 0",
                        n, d_at, hb, cons, strobe_diff(), 4 + 4 * int'(wr));
      end
    end
  endtask

  initial begin
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst_n        = 1'b0;
    test_reset();
    test_single_word();
    test_toggle();
    test_zero();
    test_max();
    test_overflow();
    test_reset_mid();
    test_start_in_data();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Serial-to-word boot loader that drives the instruction memory's preload port (`pre_ld`, `pre_A`, `pre_data`). It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written at consecutive byte addresses starting at `BASE_ADDR`. While loading, it holds the processor in reset through `cpu_hold`. It sits between the host byte channel (UART receiver or testbench) and the instruction memory.

## Interface
- `N`, 256, instruction memory size in bytes; bounds the loadable word count.
- `BASE_ADDR`, 0, byte address of the first loaded word; a multiple of 4.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; sampled in IDLE, DONE or ERR to begin a load.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `in_valid && in_ready`.
- `pre_ld`  out  1  preload write strobe to the instruction memory.
- `pre_A`  out  32  preload byte address.
- `pre_data`  out  32  preload word; `[7:0]` lands at `pre_A`.
- `cpu_hold`  out  1  high while a load is in progress; the processor is held in reset.
- `done`  out  1  one-cycle pulse when a load completes successfully.
- `err`  out  1  sticky length error; cleared by the next accepted `start`.

## Operation
- Stream format: 4-byte word count `W`, little-endian, then `4*W` data bytes. Each data word is little-endian: the first byte goes to `pre_data[7:0]`.
- `MAX_W = (N - BASE_ADDR)/4`.
- States: IDLE, LEN, DATA, SETUP, STROBE, DONE, ERR.
- IDLE/DONE/ERR with `start=1` -> LEN.
  - On that edge: clear `err`; clear the byte counter `bc` (2 bits) and the word index `wi` (32 bits).
  - Set `cpu_hold=1`.
- LEN: `in_ready=1`.
  - Each transfer shifts the byte into `W` at position `bc`, then `bc++`.
  - On the 4th byte, the next state is chosen from the assembled `W`:
    - `W==0` -> DONE.
    - `W>MAX_W` -> ERR.
    - otherwise -> DATA.
- DATA: `in_ready=1`.
  - Each transfer places the byte into the assembly register at lane `bc`, then `bc++`.
  - On the 4th byte, on the same edge:
    - `pre_data` <= the assembled word;
    - `pre_A` <= `BASE_ADDR + 4*wi`;
    - go to SETUP.
- SETUP: `pre_ld=0`, `in_ready=0`; one cycle -> STROBE. `pre_A` and `pre_data` are stable for a full cycle before the strobe, because the memory's write is level-sensitive and not address-sensitive.
- STROBE: `pre_ld=1`, `in_ready=0`; one cycle, then `wi++`.
  - `wi+1==W` -> DONE.
  - otherwise -> DATA.
- DONE: `done=1` for exactly the entry cycle; `cpu_hold=0`; otherwise idle-equivalent.
- ERR: `err=1`, `cpu_hold=0`, `in_ready=0`. No further `pre_ld` until the next `start`.
- `pre_A`/`pre_data` change only on the edge that enters SETUP; they are held in every other state.
- `start` is ignored in LEN/DATA/SETUP/STROBE.
- Bytes presented while `in_ready=0` are not consumed; the source holds them.

## Timing
- Reset (async, immediate): state=IDLE, `pre_ld=0`, `pre_A=0`, `pre_data=0`, `in_ready=0`, `cpu_hold=0`, `done=0`, `err=0`, `bc=0`, `wi=0`, `W=0`.
- Reset mid-load: the partial word is discarded, no strobe is issued, and `cpu_hold` drops immediately.
- All outputs are registered or decoded from state only; there is no combinational path from `in_valid` to any output.
- `start` -> `cpu_hold` high: 1 cycle.
- With `in_valid` held high, per word: 4 transfer cycles + SETUP + STROBE = 6 cycles. Length header: 4 cycles.
- Full load of `W` words with continuous input: `1 + 4 + 6W` cycles from `start` to the `done` pulse.
- `pre_ld` is always exactly one cycle wide, with at least 4 cycles between strobes.
- Last word (`wi == W-1`): STROBE -> DONE; no further `in_ready`.
- Boundaries:
  - `W == MAX_W` is accepted; the last `pre_A = BASE_ADDR + 4*(MAX_W-1)`.
  - `W == MAX_W+1` -> ERR.

## Test plan
- Reset, then `start`. Stream `01 00 00 00, 13 05 A0 00`, `in_valid` high. Expect:
  - one `pre_ld` pulse with `pre_A=0x0`, `pre_data=0x00A00513`;
  - `done` pulse at cycle 11;
  - `cpu_hold` high during cycles 1-10.
- 3-word load with `in_valid` toggling every other cycle. Expect:
  - strobes at `pre_A` 0x0, 0x4, 0x8 with the correct words;
  - `pre_A`/`pre_data` constant from SETUP through STROBE;
  - no byte lost or duplicated.
- `W=0`. Expect DONE after 4 header bytes, no `pre_ld`, `done` pulse, `cpu_hold` low.
- `N=256`, `BASE_ADDR=0`:
  - `W=64` -> last strobe at `pre_A=0xFC`;
  - `W=65` -> ERR, `err=1`, `in_ready=0`, no strobe;
  - next `start` clears `err`.
- Assert `rst_n=0` in the middle of the 2nd word's bytes. Expect all outputs at reset values at once, no further `pre_ld`, and a clean reload on the next `start`.
- Pulse `start` during DATA. Expect no effect: `wi`, `bc` and `err` unchanged, and the load completes normally.
